multibyte_add_sequencer: RTL and testbench



---
 rtl/add_seq_pkg.sv | 17 +
 rtl/multibyte_add_sequencer_if.sv | 37 +++
 rtl/multibyte_add_sequencer.sv | 110 +++++++++++
 tb/tb_multibyte_add_sequencer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/add_seq_pkg.sv
// Shared types and helpers for the multi-byte add sequencer.
package add_seq_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Byte index width; never narrower than one bit.
    function automatic int idx_width(input int nb);
        return (nb > 1) ? $clog2(nb) : 1;
    endfunction

endpackage

// File: rtl/multibyte_add_sequencer_if.sv
// Operand/result handshake bundle for multibyte_add_sequencer.
// Optional SEQ_SUB_EN adds the op_sub request bit.
interface multibyte_add_sequencer_if #(
    parameter int NUM_BYTES = 4
);
    localparam int W = add_seq_pkg::BYTE_W * NUM_BYTES;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         op_cin;
`ifdef SEQ_SUB_EN
    logic         op_sub;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         carry_out;

    modport master (
`ifdef SEQ_SUB_EN
        output op_sub,
`endif
        output in_valid, op_a, op_b, op_cin, out_ready,
        input  in_ready, out_valid, result, carry_out
    );

    modport slave (
`ifdef SEQ_SUB_EN
        input  op_sub,
`endif
        input  in_valid, op_a, op_b, op_cin, out_ready,
        output in_ready, out_valid, result, carry_out
    );

endinterface

// File: rtl/multibyte_add_sequencer.sv
// Feeds an external 8-bit adder one byte per cycle, LSB first, chaining carries.
// Define SEQ_SUB_EN to add op_sub (A - B via inverted B and forced carry-in).
module multibyte_add_sequencer
    import add_seq_pkg::*;
#(
    parameter int NUM_BYTES = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    multibyte_add_sequencer_if.slave         bus,
    output logic [BYTE_W-1:0]                add_a,
    output logic [BYTE_W-1:0]                add_b,
    output logic                             add_cin,
    input  logic [BYTE_W-1:0]                add_sum,
    input  logic                             add_cout
);

    localparam int W     = BYTE_W * NUM_BYTES;
    localparam int IDX_W = idx_width(NUM_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_RUN  = RUN;
    localparam logic [1:0] ST_DONE = DONE;

    logic [1:0]        state_reg;
    logic [IDX_W-1:0]  byte_idx_reg;
    logic              carry_reg;
    logic              carry_out_reg;
    logic [W-1:0]      a_reg;
    logic [W-1:0]      b_reg;
    logic [BYTE_W-1:0] a_bytes   [NUM_BYTES];
    logic [BYTE_W-1:0] b_bytes   [NUM_BYTES];
    logic [BYTE_W-1:0] res_bytes [NUM_BYTES];
    logic              sub_sel;
    logic              run_active;

`ifdef SEQ_SUB_EN
    assign sub_sel = bus.op_sub;
`else
    assign sub_sel = 1'b0;
`endif

    assign run_active = (state_reg == ST_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            byte_idx_reg  <= '0;
            carry_reg     <= 1'b0;
            carry_out_reg <= 1'b0;
            a_reg         <= '0;
            b_reg         <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        a_reg        <= bus.op_a;
                        // Subtraction is A + ~B + 1; carry_out then means "no borrow".
                        b_reg        <= sub_sel ? ~bus.op_b : bus.op_b;
                        carry_reg    <= sub_sel ? 1'b1 : bus.op_cin;
                        byte_idx_reg <= '0;
                        state_reg    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    carry_reg <= add_cout;
                    if (byte_idx_reg == LAST_IDX) begin
                        carry_out_reg <= add_cout;
                        byte_idx_reg  <= '0;
                        state_reg     <= ST_DONE;
                    end else begin
                        byte_idx_reg <= byte_idx_reg + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Per-lane byte views and result capture; each lane owns its own register.
    generate
        for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_lane
            assign a_bytes[gi] = a_reg[gi*BYTE_W +: BYTE_W];
            assign b_bytes[gi] = b_reg[gi*BYTE_W +: BYTE_W];
            assign bus.result[gi*BYTE_W +: BYTE_W] = res_bytes[gi];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    res_bytes[gi] <= '0;
                end else if (run_active && (byte_idx_reg == IDX_W'(gi))) begin
                    res_bytes[gi] <= add_sum;
                end
            end
        end
    endgenerate

    assign add_a         = run_active ? a_bytes[byte_idx_reg] : '0;
    assign add_b         = run_active ? b_bytes[byte_idx_reg] : '0;
    assign add_cin       = run_active ? carry_reg : 1'b0;
    assign bus.in_ready  = (state_reg == ST_IDLE);
    assign bus.out_valid = (state_reg == ST_DONE);
    assign bus.carry_out = carry_out_reg;

endmodule

// File: tb/tb_multibyte_add_sequencer.sv
// Self-checking bench: directed and random transactions against an arithmetic reference.
module tb_multibyte_add_sequencer;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multibyte_add_sequencer_if #(.NUM_BYTES(NB)) bus ();

    logic [7:0] add_a, add_b, add_sum;
    logic       add_cin, add_cout;

    // External 8-bit adder, purely combinational.
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};

    multibyte_add_sequencer #(.NUM_BYTES(NB)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_sum  (add_sum),
        .add_cout (add_cout)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("%s miscompare", tag);
        end
    endtask

    // Reference: wide sum (carry in MSB) from plain arithmetic.
    function automatic logic [W:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin, input logic sub);
        if (sub) return {(a >= b), a - b};
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    endfunction

    // Reference: carry entering byte k (for subtraction, "no borrow so far").
    function automatic logic ref_carry_in(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic cin, input logic sub, input int k);
        logic [63:0] m, al, bl, s;
        m  = (64'd1 << (8 * k)) - 64'd1;
        al = {32'd0, a} & m;
        bl = {32'd0, b} & m;
        if (sub) return (al >= bl);
        s = al + bl + {63'd0, cin};
        return s[8*k];
    endfunction

    task automatic drive_ops(input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic cin, input logic sub);
        bus.op_a   = a;
        bus.op_b   = b;
        bus.op_cin = cin;
`ifdef SEQ_SUB_EN
        bus.op_sub = sub;
`else
        if (sub) bus.op_cin = cin;
`endif
    endtask

    task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub);
        int n;
        n = 0;
        drive_ops(a, b, cin, sub);
        bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("accept_wait", {63'd0, (n < 50)}, 64'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        drive_ops($urandom(), $urandom(), 1'($urandom()), 1'($urandom()));
    endtask

    task automatic execute(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                           input logic sub, input int hold, input bit b2b);
        logic [W:0]   exp;
        logic [W-1:0] beff;
        exp  = ref_sum(a, b, cin, sub);
        beff = sub ? ~b : b;
        for (int k = 0; k < NB; k++) begin
            chk("run_out_valid", {63'd0, bus.out_valid}, 64'd0);
            chk("run_in_ready", {63'd0, bus.in_ready}, 64'd0);
            chk("run_add_a", {56'd0, add_a}, {56'd0, a[8*k +: 8]});
            chk("run_add_b", {56'd0, add_b}, {56'd0, beff[8*k +: 8]});
            chk("run_add_cin", {63'd0, add_cin}, {63'd0, ref_carry_in(a, b, cin, sub, k)});
            @(posedge clk); #1;
        end
        chk("latency_out_valid", {63'd0, bus.out_valid}, 64'd1);
        chk("result", {32'd0, bus.result}, {32'd0, exp[W-1:0]});
        chk("carry_out", {63'd0, bus.carry_out}, {63'd0, exp[W]});
        chk("done_in_ready", {63'd0, bus.in_ready}, 64'd0);
        if (!b2b) begin
            bus.in_valid = 1'b1;
            drive_ops($urandom(), $urandom(), 1'($urandom()), 1'($urandom()));
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("hold_out_valid", {63'd0, bus.out_valid}, 64'd1);
            chk("hold_result", {32'd0, bus.result}, {32'd0, exp[W-1:0]});
            chk("hold_carry_out", {63'd0, bus.carry_out}, {63'd0, exp[W]});
            chk("hold_in_ready", {63'd0, bus.in_ready}, 64'd0);
            chk("hold_add_cin", {63'd0, add_cin}, 64'd0);
        end
        if (!b2b) bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("post_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("post_in_ready", {63'd0, bus.in_ready}, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] ra, rb;
        logic         rc, rs;
        int           rh;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        drive_ops('0, '0, 1'b0, 1'b0);

        // Reset state
        #12;
        chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst_result", {32'd0, bus.result}, 64'd0);
        chk("rst_carry_out", {63'd0, bus.carry_out}, 64'd0);
        chk("rst_add_a", {56'd0, add_a}, 64'd0);
        chk("rst_add_b", {56'd0, add_b}, 64'd0);
        chk("rst_add_cin", {63'd0, add_cin}, 64'd0);
        #5 rst_n = 1'b1;
        @(posedge clk); #1;

        // Byte carry into byte 1
        accept(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
        execute(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 0, 1'b0);
        chk("const_ff_plus_1", {32'd0, bus.result}, 64'h0000_0100);

        // Carry ripples through every byte
        accept(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
        execute(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 0, 1'b0);
        chk("const_ripple_cout", {63'd0, bus.carry_out}, 64'd1);

        // Backpressure for three cycles
        accept(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
        execute(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 3, 1'b0);
        chk("const_bp_result", {32'd0, bus.result}, 64'h2345_6789);

        // Asynchronous reset mid-RUN at byte 2
        accept(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("abort_in_ready", {63'd0, bus.in_ready}, 64'd1);
        chk("abort_add_a", {56'd0, add_a}, 64'd0);
        chk("abort_add_b", {56'd0, add_b}, 64'd0);
        chk("abort_add_cin", {63'd0, add_cin}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("release_out_valid", {63'd0, bus.out_valid}, 64'd0);
            chk("release_in_ready", {63'd0, bus.in_ready}, 64'd1);
        end
        accept(32'h1, 32'h1, 1'b0, 1'b0);
        execute(32'h1, 32'h1, 1'b0, 1'b0, 0, 1'b0);
        chk("const_after_abort", {32'd0, bus.result}, 64'h0000_0002);

        // Back-to-back with in_valid held high
        accept(32'hA5A5_0F0F, 32'h5A5A_F0F1, 1'b0, 1'b0);
        drive_ops(32'h0102_0304, 32'hFF00_FF00, 1'b1, 1'b0);
        bus.in_valid = 1'b1;
        execute(32'hA5A5_0F0F, 32'h5A5A_F0F1, 1'b0, 1'b0, 1, 1'b1);
        @(posedge clk); #1;
        chk("b2b_accepted", {63'd0, bus.in_ready}, 64'd0);
        bus.in_valid = 1'b0;
        execute(32'h0102_0304, 32'hFF00_FF00, 1'b1, 1'b0, 0, 1'b0);

`ifdef SEQ_SUB_EN
        // Subtraction with and without borrow
        accept(32'h5, 32'h7, 1'b0, 1'b1);
        execute(32'h5, 32'h7, 1'b0, 1'b1, 0, 1'b0);
        chk("const_sub_borrow", {31'd0, bus.carry_out, bus.result}, {31'd0, 1'b0, 32'hFFFF_FFFE});
        accept(32'h7, 32'h5, 1'b1, 1'b1);
        execute(32'h7, 32'h5, 1'b1, 1'b1, 0, 1'b0);
        chk("const_sub_noborrow", {31'd0, bus.carry_out, bus.result}, {31'd0, 1'b1, 32'h0000_0002});
`endif

        // Randomized transactions
        for (int t = 0; t < 24; t++) begin
            ra = $urandom();
            rb = (t % 4 == 0) ? ~ra : $urandom();
            rc = 1'($urandom());
`ifdef SEQ_SUB_EN
            rs = 1'($urandom());
`else
            rs = 1'b0;
`endif
            rh = $urandom_range(0, 2);
            accept(ra, rb, rc, rs);
            execute(ra, rb, rc, rs, rh, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
